// File: rtl/dmem_port_arbiter.sv
// Data-port arbiter between CPU load/store and a DMA master; CPU has priority,
// a starvation counter forces a one-cycle DMA slot. Optional stats: ARB_STAT_EN.
module dmem_port_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [DWIDTH-1:0] dma_wdata,
    input  logic [3:0]        dma_be,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DWIDTH-1:0] dma_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
`ifdef ARB_STAT_EN
    ,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_dma_cnt
`endif
);

    typedef enum logic {S_CPU, S_FORCE} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

    // Last denied cycle before the count would reach MAX_WAIT.
    localparam logic [3:0] LP_WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_rd_owner;
    owner_t      w_owner_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_nxt;
    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_unused;

    assign w_unused = ^{cpu_addr[31:AWIDTH+2], cpu_addr[1:0],
                        dma_addr[31:AWIDTH+2], dma_addr[1:0]};

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = S_CPU;
        w_cpu_gnt   = 1'b0;
        w_dma_gnt   = 1'b0;
        cpu_stall   = 1'b0;
        unique case (r_state)
            S_CPU: begin
                w_cpu_gnt = cpu_req;
                w_dma_gnt = dma_req & ~cpu_req;
                if (dma_req && !w_dma_gnt && (r_wait_cnt == LP_WAIT_LAST))
                    w_state_nxt = S_FORCE;
            end
            S_FORCE: begin
                w_dma_gnt = 1'b1;
                cpu_stall = cpu_req;
            end
            default: w_state_nxt = S_CPU;
        endcase
        // Reset forces every output low immediately, not just at the next edge.
        if (reset) begin
            w_state_nxt = S_CPU;
            w_cpu_gnt   = 1'b0;
            w_dma_gnt   = 1'b0;
            cpu_stall   = 1'b0;
        end
    end

    always_comb begin
        if (!dma_req || w_dma_gnt || (w_state_nxt == S_FORCE))
            w_wait_nxt = 4'd0;
        else
            w_wait_nxt = r_wait_cnt + 4'd1;
    end

    always_comb begin
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_be      = 4'h0;
        mem_wdata   = '0;
        w_owner_nxt = OWN_NONE;
        if (w_cpu_gnt) begin
            mem_addr    = cpu_addr[AWIDTH+1:2];
            mem_we      = cpu_we;
            mem_be      = cpu_be;
            mem_wdata   = cpu_wdata;
            w_owner_nxt = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (w_dma_gnt) begin
            mem_addr    = dma_addr[AWIDTH+1:2];
            mem_we      = dma_we;
            mem_be      = dma_be;
            mem_wdata   = dma_wdata;
            w_owner_nxt = dma_we ? OWN_NONE : OWN_DMA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_CPU;
            r_wait_cnt <= 4'd0;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_rd_owner <= w_owner_nxt;
        end
    end

    assign dma_gnt    = w_dma_gnt;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_rvalid = (r_rd_owner == OWN_DMA);

`ifdef ARB_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stall_cnt <= 32'd0;
            stat_dma_cnt   <= 32'd0;
        end else begin
            if (cpu_stall) stat_stall_cnt <= stat_stall_cnt + 32'd1;
            if (w_dma_gnt) stat_dma_cnt   <= stat_dma_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data port of the instruction/data RAM between the CPU load/store path and a second bus master (DMA / UART boot loader).
- The memory has synchronous read; write-enable and byte-enables are applied at the clock edge.
- CPU has priority. The DMA master is guaranteed service by a starvation counter, which forces a DMA slot and stalls the CPU for one cycle.
- Sits between the CPU/DMA and the memory data port, after address decode.

Parameters:
- DWIDTH, 32, data width.
- AWIDTH, 12, memory word-address width; mem_addr = addr[AWIDTH+1:2].
- MAX_WAIT, 4, consecutive denied DMA-request cycles before a forced DMA slot (legal range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU data access valid this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  DWIDTH  CPU write data
- cpu_be  in  4  CPU byte enables
- cpu_rdata  out  DWIDTH  read data, valid the cycle after an accepted CPU read
- cpu_stall  out  1  CPU access not accepted this cycle; CPU must hold its request
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write / read
- dma_addr  in  32  DMA byte address
- dma_wdata  in  DWIDTH  DMA write data
- dma_be  in  4  DMA byte enables
- dma_gnt  out  1  DMA access accepted this cycle
- dma_rvalid  out  1  dma_rdata valid (cycle after a granted DMA read)
- dma_rdata  out  DWIDTH  DMA read data
- mem_addr  out  AWIDTH  memory word address
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data (1-cycle latency)

Behaviour:
- Grant is combinational within the cycle; the access is taken at the next rising clk edge.
- State machine:
  - S_CPU (reset state): grant the CPU if cpu_req, else the DMA if dma_req.
  - S_FORCE: grant the DMA unconditionally (dma_req is high here by construction). cpu_stall = cpu_req. Returns to S_CPU after one cycle.
- wait_cnt (4 bits) controls entry to S_FORCE:
  - Increments each cycle dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or dma_req=0.
  - When wait_cnt reaches MAX_WAIT, the FSM goes to S_CPU→S_FORCE next cycle.
  - Entering S_FORCE clears wait_cnt.
- In S_CPU, cpu_stall is always 0 and dma_gnt = dma_req & ~cpu_req.
- Mux: the granted master drives mem_addr, mem_be, mem_wdata and mem_we. mem_we = granted master's we. With no grant, mem_we=0 and mem_be=0.
- rd_owner register (2 bits: none/CPU/DMA) is set at the edge from the granted master's read. It is none for writes and for idle cycles.
- Read data return:
  - cpu_rdata = mem_rdata, unregistered.
  - dma_rdata = mem_rdata.
  - dma_rvalid = (rd_owner==DMA).
- Simultaneous events:
  - CPU and DMA both request in S_CPU: CPU wins, DMA waits.
  - A DMA write and a following CPU read to the same address in consecutive cycles: the CPU sees the new data. The memory is write-first; the arbiter adds nothing.
- dma_req dropped while waiting: wait_cnt clears, and there is no forced slot.
- Reset, asynchronous and mid-operation:
  - State → S_CPU; wait_cnt=0; rd_owner=none.
  - All outputs go low immediately (mem_we=0, dma_gnt=0, cpu_stall=0, dma_rvalid=0).
  - Any in-flight read is discarded.

Optional Feature:
- ARB_STAT_EN defined:
  - Adds outputs stat_stall_cnt[31:0] (cycles with cpu_stall=1) and stat_dma_cnt[31:0] (cycles with dma_gnt=1).
  - Both are cleared by reset and wrap at 2^32.
- ARB_STAT_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- CPU read only: cpu_req=1, cpu_we=0, cpu_addr=0x10, memory word 4 = 0xDEADBEEF → mem_addr=4, cpu_stall=0; cycle+1 cpu_rdata=0xDEADBEEF, dma_rvalid=0.
- DMA alone: dma_req=1, dma_we=1, dma_addr=0x20, dma_wdata=0x12345678, be=4'hF → dma_gnt=1 the same cycle, mem_we=1, mem_addr=8; a DMA read of 0x20 the next cycle gives dma_rvalid=1 with 0x12345678 one cycle later.
- Contention, MAX_WAIT=4: cpu_req and dma_req held high continuously:
  - dma_gnt=0 for 4 cycles, then a forced slot with dma_gnt=1 and cpu_stall=1 for exactly 1 cycle.
  - The pattern repeats every 5 cycles.
  - CPU address and data are held while stalled, and its access completes the next cycle.
- DMA drops its request after 3 denied cycles, then re-raises it → wait_cnt has restarted from 0, and the forced slot comes 4 denied cycles after the re-raise.
- Reset asserted during a forced slot with a DMA read pending → outputs go low asynchronously and dma_rvalid stays 0. After release, the FSM is in S_CPU and the first CPU request is granted without a stall.
- ARB_STAT_EN build: run the contention test for 20 cycles → stat_stall_cnt=4, stat_dma_cnt=4.
